weight_fetch_seq: RTL

Read sequencer for the registered, single-port weight memory of the NN fully-connected engine. On `start`, it issues one read per cycle over a contiguous range of weight words. Returned words go into a 2-entry buffer and leave as a valid/ready stream with a last-word flag. Credit-based issue absorbs the memory's 1-cycle read latency, so no word is lost under backpressure; throughput is 1 word/cycle when the consumer is always ready.

---
 rtl/nnfc_pkg.sv | 14 +
 rtl/weight_skid_fifo.sv | 59 +++++
 rtl/weight_fetch_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/nnfc_pkg.sv
// Shared types and constants for the NN fully-connected engine.
package nnfc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } wfs_state_t;

  localparam int WFS_BUF_DEPTH = 2;
  localparam int WFS_PTR_W     = $clog2(WFS_BUF_DEPTH);
  localparam int WFS_CNT_W     = $clog2(WFS_BUF_DEPTH + 1);

endpackage

// File: rtl/weight_skid_fifo.sv
// Small synchronous FIFO that holds weight words returned by the memory
// until the stream consumer takes them.
module weight_skid_fifo
  import nnfc_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [WFS_CNT_W-1:0]  count,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam logic [WFS_PTR_W-1:0] LAST_PTR  = WFS_PTR_W'(WFS_BUF_DEPTH - 1);
  localparam logic [WFS_CNT_W-1:0] DEPTH_CNT = WFS_CNT_W'(WFS_BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [WFS_BUF_DEPTH];
  logic [WFS_PTR_W-1:0]  wr_ptr;
  logic [WFS_PTR_W-1:0]  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full      = (count == DEPTH_CNT);
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];
  assign do_pop    = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push   = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < WFS_BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!do_push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_fetch_seq.sv
// Read sequencer for the weight memory: issues contiguous reads with credit
// flow control and presents the returned words as a valid/ready stream.
module weight_fetch_seq
  import nnfc_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_r_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  output logic                  w_last,
  input  logic                  w_ready
);

  localparam logic [ADDR_WIDTH:0]  CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [WFS_CNT_W-1:0] DEPTH_CNT = WFS_CNT_W'(WFS_BUF_DEPTH);

  wfs_state_t state;
  wfs_state_t state_nxt;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   pop_cnt;
  logic                  inflight_q;
  logic                  done_q;
  logic                  accept;
  logic                  zero_start;
  logic                  seq_end;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [WFS_CNT_W-1:0]  fifo_count;
  logic [WFS_CNT_W-1:0]  occ;

  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign w_valid    = !fifo_empty;
  assign w_last     = w_valid && (pop_cnt == num_q - CNT_ONE);
  assign pop        = w_valid && w_ready;
  assign issue_addr = base_q + issue_cnt[ADDR_WIDTH-1:0];
  assign mem_addr   = mem_r_en ? issue_addr : last_addr_q;
  // Credits: every read in flight already owns a buffer slot.
  assign occ        = fifo_count + WFS_CNT_W'(inflight_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_r_en   = 1'b0;
    accept     = 1'b0;
    zero_start = 1'b0;
    seq_end    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            accept    = 1'b1;
            state_nxt = FETCH;
          end else begin
            zero_start = 1'b1;
          end
        end
      end
      FETCH: begin
        if ((occ < DEPTH_CNT) || ((occ == DEPTH_CNT) && pop)) begin
          mem_r_en = 1'b1;
          if (issue_cnt == num_q - CNT_ONE) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && w_last) begin
          seq_end   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q      <= '0;
      num_q       <= '0;
      issue_cnt   <= '0;
      pop_cnt     <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q     <= zero_start || seq_end;
      inflight_q <= mem_r_en;
      if (accept) begin
        base_q    <= base_addr;
        num_q     <= num_words;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (mem_r_en) begin
          issue_cnt   <= issue_cnt + CNT_ONE;
          last_addr_q <= issue_addr;
        end
        if (pop) begin
          pop_cnt <= pop_cnt + CNT_ONE;
        end
      end
    end
  end

  // Reset drops inflight_q, so a beat returning after reset is never pushed.
  weight_skid_fifo #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_q),
    .push_data(mem_data),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head_data(w_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(inflight_q && fifo_full && !pop));
    end
  end

endmodule
